// File: rtl/nibble_hs_pkg.sv
// Shared types and constants for the nibble four-phase handshake server.
package nibble_hs_pkg;

  localparam int unsigned DATA_W_DEF    = 4;
  localparam int unsigned PAUSE_W       = 4;
  localparam logic [3:0]  LFSR_TAPS     = 4'b1100;  // x^4 + x^3 + 1
  localparam logic [3:0]  LFSR_SEED_DEF = 4'hA;

  typedef enum logic [1:0] {IDLE, PRE, ACK, POST} hs_state_e;

endpackage

// File: rtl/nibble_handshake_server_if.sv
// Bus and upstream-source signals of the nibble handshake server.
interface nibble_handshake_server_if #(
  parameter int unsigned DATA_W = nibble_hs_pkg::DATA_W_DEF,
  parameter int unsigned CNT_W  = 16
);

  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              client_ready;
  logic              server_ready;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  xfer_count;
  logic              proto_err;

  modport slave (
    input  src_valid, src_data, client_ready,
    output src_ready, server_ready, data, xfer_count, proto_err
  );

  modport master (
    output src_valid, src_data, client_ready,
    input  src_ready, server_ready, data, xfer_count, proto_err
  );

endinterface

// File: rtl/hs_pause_timer.sv
// Pause down-counter; with NIBBLE_HS_PAUSE_EN each pause length comes from a
// free-running 4-bit LFSR, otherwise every pause is one cycle.
module hs_pause_timer
  import nibble_hs_pkg::*;
#(
  parameter logic [PAUSE_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic done_o
);

  logic [PAUSE_W-1:0] cnt_q;
  logic [PAUSE_W-1:0] load_val;
  logic               done_q;

  if (SEED == '0) begin : g_bad_seed
    $error("hs_pause_timer: SEED must be non-zero");
  end

`ifdef NIBBLE_HS_PAUSE_EN
  logic [PAUSE_W-1:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= {lfsr_q[PAUSE_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign load_val = lfsr_q;
`else
  assign load_val = PAUSE_W'(1);
`endif

  // done is raised on the edge the count reaches zero, so a loaded pause of
  // N keeps the owning state for N+1 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else if (load_i) begin
      cnt_q  <= load_val;
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - PAUSE_W'(1);
      done_q <= (cnt_q == PAUSE_W'(1));
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/nibble_handshake_server.sv
// Server side of the main_bus four-phase nibble handshake.
// Optional pseudo-random wait states: define NIBBLE_HS_PAUSE_EN.
module nibble_handshake_server
  import nibble_hs_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [3:0]  LFSR_SEED   = LFSR_SEED_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_handshake_server_if.slave  bus
);

  hs_state_e         state_q;
  logic              srv_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  xfer_q;
  logic              err_q;
  logic              cr;
  logic              accept;
  logic              pause_load;
  logic              pause_done;

  if (SYNC_STAGES > 3) begin : g_bad_sync
    $error("nibble_handshake_server: SYNC_STAGES must be 0..3");
  end

  if (SYNC_STAGES == 0) begin : g_nosync
    assign cr = bus.client_ready;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= (sync_q << 1) | SYNC_STAGES'(bus.client_ready);
    end
    assign cr = sync_q[SYNC_STAGES-1];
  end

  assign accept     = (state_q == IDLE) && cr && bus.src_valid;
  assign pause_load = accept || ((state_q == ACK) && !cr);

  hs_pause_timer #(
    .SEED   (LFSR_SEED)
  ) u_pause (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pause_load),
    .done_o (pause_done)
  );

  // Handshake FSM; a client drop during PRE is flagged but the cycle completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      srv_q   <= 1'b0;
      data_q  <= '0;
      xfer_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= bus.src_data;
            state_q <= PRE;
          end
        end
        PRE: begin
          if (!cr) err_q <= 1'b1;
          if (pause_done) begin
            srv_q   <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (!cr) state_q <= POST;
        end
        POST: begin
          if (pause_done) begin
            srv_q   <= 1'b0;
            xfer_q  <= xfer_q + CNT_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.src_ready    = accept;
  assign bus.server_ready = srv_q;
  assign bus.data         = data_q;
  assign bus.xfer_count   = xfer_q;
  assign bus.proto_err    = err_q;

endmodule

// File: tb/tb_nibble_handshake_server.sv
// Directed self-checking bench for nibble_handshake_server (SYNC_STAGES=0).
// Define NIBBLE_HS_PAUSE_EN to also exercise the pseudo-random pause build.
module tb_nibble_handshake_server;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  nibble_handshake_server_if #(.DATA_W(4), .CNT_W(16)) bus ();

  nibble_handshake_server #(
    .DATA_W      (4),
    .SYNC_STAGES (0),
    .LFSR_SEED   (4'hA),
    .CNT_W       (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data = 4'h0;
    bus.client_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full handshake; reports PRE and POST lengths in edges.
  task automatic do_xfer(input logic [3:0] w, output int pre_n, output int post_n);
    int n;
    bus.src_valid = 1'b1;
    bus.src_data = w;
    bus.client_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.src_ready && n < 40) begin tick(); n++; end
    checks++;
    if (bus.src_ready !== 1'b1) begin
      failures++; $display("FAIL xfer_accept w=%h src_ready=%b need 1", w, bus.src_ready);
    end
    tick();
    bus.src_valid = 1'b0;
    checks++;
    if (bus.data !== w) begin
      failures++; $display("FAIL xfer_data_latch got %h need %h", bus.data, w);
    end
    pre_n = 0;
    while (!bus.server_ready && pre_n < 40) begin tick(); pre_n++; end
    checks++;
    if (bus.server_ready !== 1'b1 || bus.data !== w) begin
      failures++; $display("FAIL xfer_rise srv=%b data=%h need 1 %h", bus.server_ready, bus.data, w);
    end
    bus.client_ready = 1'b0;
    post_n = 0;
    while (bus.server_ready && post_n < 40) begin tick(); post_n++; end
    checks++;
    if (bus.server_ready !== 1'b0 || bus.data !== w) begin
      failures++; $display("FAIL xfer_fall srv=%b data=%h need 0 %h", bus.server_ready, bus.data, w);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.server_ready, bus.data, bus.xfer_count, bus.proto_err, bus.src_ready} !== 23'h0) begin
      failures++;
      $display("FAIL reset_state srv=%b data=%h cnt=%0d err=%b srdy=%b need all 0",
               bus.server_ready, bus.data, bus.xfer_count, bus.proto_err, bus.src_ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    bus.src_valid = 1'b1;
    bus.src_data = 4'h5;
    bus.client_ready = 1'b1;
    #1;
    checks++;
    if (bus.src_ready !== 1'b1) begin
      failures++; $display("FAIL single_src_ready got %b need 1", bus.src_ready);
    end
    tick();
    bus.src_valid = 1'b0;
    #1;
    checks++;
    if (bus.data !== 4'h5 || bus.server_ready !== 1'b0 || bus.src_ready !== 1'b0) begin
      failures++; $display("FAIL single_accept data=%h srv=%b srdy=%b need 5 0 0",
                           bus.data, bus.server_ready, bus.src_ready);
    end
    tick();
    checks++;
    if (bus.server_ready !== 1'b0) begin
      failures++; $display("FAIL single_edge1 srv=%b need 0", bus.server_ready);
    end
    tick();
    checks++;
    if (bus.server_ready !== 1'b1) begin
      failures++; $display("FAIL single_edge2 srv=%b need 1", bus.server_ready);
    end
    bus.client_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.server_ready !== 1'b1 || bus.data !== 4'h5) begin
      failures++; $display("FAIL single_post_hold srv=%b data=%h need 1 5", bus.server_ready, bus.data);
    end
    tick();
    checks++;
    if (bus.server_ready !== 1'b0 || bus.data !== 4'h5 || bus.xfer_count !== 16'd1) begin
      failures++; $display("FAIL single_fall srv=%b data=%h cnt=%0d need 0 5 1",
                           bus.server_ready, bus.data, bus.xfer_count);
    end
  endtask

  task automatic test_six();
    logic [3:0] words [6];
    int pre_n, post_n;
    words = '{4'h3, 4'h9, 4'hA, 4'h0, 4'hF, 4'h6};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      do_xfer(words[i], pre_n, post_n);
`ifndef NIBBLE_HS_PAUSE_EN
      checks++;
      if (pre_n != 2 || post_n != 3) begin
        failures++; $display("FAIL six_timing i=%0d pre=%0d post=%0d need 2 3", i, pre_n, post_n);
      end
`endif
    end
    checks++;
    if (bus.xfer_count !== 16'd6 || bus.proto_err !== 1'b0) begin
      failures++; $display("FAIL six_count cnt=%0d err=%b need 6 0", bus.xfer_count, bus.proto_err);
    end
  endtask

  task automatic test_proto_err();
    int n;
    int pre_n, post_n;
    bus.src_valid = 1'b1;
    bus.src_data = 4'hC;
    bus.client_ready = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    bus.client_ready = 1'b0;
    tick();
    checks++;
    if (bus.proto_err !== 1'b1 || bus.server_ready !== 1'b0) begin
      failures++; $display("FAIL proto_flag err=%b srv=%b need 1 0", bus.proto_err, bus.server_ready);
    end
    n = 0;
    while (!bus.server_ready && n < 40) begin tick(); n++; end
    checks++;
    if (bus.server_ready !== 1'b1) begin
      failures++; $display("FAIL proto_pulse_rise srv=%b need 1", bus.server_ready);
    end
    n = 0;
    while (bus.server_ready && n < 40) begin tick(); n++; end
    checks++;
    if (bus.server_ready !== 1'b0 || bus.xfer_count !== 16'd7 || bus.proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_complete srv=%b cnt=%0d err=%b need 0 7 1",
                           bus.server_ready, bus.xfer_count, bus.proto_err);
    end
    do_xfer(4'h2, pre_n, post_n);
    checks++;
    if (bus.proto_err !== 1'b1 || bus.xfer_count !== 16'd8) begin
      failures++; $display("FAIL proto_sticky err=%b cnt=%0d need 1 8", bus.proto_err, bus.xfer_count);
    end
  endtask

  task automatic test_post_ignore();
    int n;
    int pre_n, post_n;
    apply_reset();
    bus.src_valid = 1'b1;
    bus.src_data = 4'h4;
    bus.client_ready = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    tick();
    tick();
    bus.client_ready = 1'b0;
    tick();
    bus.client_ready = 1'b1;
    bus.src_valid = 1'b1;
    bus.src_data = 4'hB;
    #1;
    checks++;
    if (bus.src_ready !== 1'b0) begin
      failures++; $display("FAIL post_ignore_a srdy=%b need 0", bus.src_ready);
    end
    tick();
    checks++;
    if (bus.src_ready !== 1'b0 || bus.server_ready !== 1'b1 || bus.data !== 4'h4) begin
      failures++; $display("FAIL post_ignore_b srdy=%b srv=%b data=%h need 0 1 4",
                           bus.src_ready, bus.server_ready, bus.data);
    end
    tick();
    checks++;
    if (bus.server_ready !== 1'b0 || bus.src_ready !== 1'b1 || bus.data !== 4'h4) begin
      failures++; $display("FAIL post_ignore_idle srv=%b srdy=%b data=%h need 0 1 4",
                           bus.server_ready, bus.src_ready, bus.data);
    end
    do_xfer(4'hB, pre_n, post_n);
    n = 0;
    checks++;
    if (bus.xfer_count !== 16'd2) begin
      failures++; $display("FAIL post_ignore_count cnt=%0d need 2", bus.xfer_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int pre_n, post_n;
    apply_reset();
    bus.src_valid = 1'b1;
    bus.src_data = 4'hD;
    bus.client_ready = 1'b1;
    tick();
    bus.src_valid = 1'b0;
    n = 0;
    while (!bus.server_ready && n < 40) begin tick(); n++; end
    rst_n = 1'b0;
    bus.client_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.server_ready !== 1'b0 || bus.data !== 4'h0 || bus.xfer_count !== 16'd0 ||
        bus.proto_err !== 1'b0) begin
      failures++; $display("FAIL reset_mid srv=%b data=%h cnt=%0d err=%b need 0 0 0 0",
                           bus.server_ready, bus.data, bus.xfer_count, bus.proto_err);
    end
    do_xfer(4'h7, pre_n, post_n);
    checks++;
    if (bus.xfer_count !== 16'd1 || bus.proto_err !== 1'b0) begin
      failures++; $display("FAIL reset_mid_fresh cnt=%0d err=%b need 1 0", bus.xfer_count, bus.proto_err);
    end
  endtask

`ifdef NIBBLE_HS_PAUSE_EN
  task automatic test_pause();
    int pre_a [6];
    int post_a [6];
    int pre_n, post_n;
    logic [3:0] w;
    apply_reset();
    for (int i = 0; i < 6; i++) do_xfer(4'(i + 1), pre_a[i], post_a[i]);
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      do_xfer(4'(i + 1), pre_n, post_n);
      checks++;
      if (pre_n != pre_a[i] || post_n != post_a[i]) begin
        failures++; $display("FAIL pause_repeat i=%0d pre=%0d post=%0d need %0d %0d",
                             i, pre_n, post_n, pre_a[i], post_a[i]);
      end
    end
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      w = 4'((i * 7 + 3) % 16);
      do_xfer(w, pre_n, post_n);
      checks++;
      if (pre_n < 2 || pre_n > 16 || post_n < 3 || post_n > 17) begin
        failures++; $display("FAIL pause_range i=%0d pre=%0d post=%0d need 2..16 3..17", i, pre_n, post_n);
      end
    end
    checks++;
    if (bus.xfer_count !== 16'd20) begin
      failures++; $display("FAIL pause_count cnt=%0d need 20", bus.xfer_count);
    end
  endtask
`endif

  initial begin
    bus.src_valid = 1'b0;
    bus.src_data = 4'h0;
    bus.client_ready = 1'b0;
    test_reset();
    test_single();
    test_six();
    test_proto_err();
    test_post_ignore();
    test_reset_mid();
`ifdef NIBBLE_HS_PAUSE_EN
    test_pause();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
